// File: rtl/mcd212_video_timing.sv
// mcd212_video_timing
// Raster timing generator for the MCD212 display path. Pixel clock enables are
// counted into horizontal/vertical positions; sync, blanking, display-active,
// field parity and a sticky programmable line interrupt are decoded from them.
// Every decode is taken from the next-state counters and registered alongside
// them, so outputs always agree with h_count/v_count in the same clock.
module mcd212_video_timing #(
  parameter int H_TOTAL       = 944,
  parameter int H_ACTIVE      = 768,
  parameter int HS_START      = 800,
  parameter int HS_WIDTH      = 70,
  parameter int V_TOTAL_PAL   = 312,
  parameter int V_ACTIVE_PAL  = 280,
  parameter int V_TOTAL_NTSC  = 262,
  parameter int V_ACTIVE_NTSC = 240,
  parameter int VS_OFFSET     = 4,
  parameter int VS_WIDTH      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pixel_ce,
  input  logic       pal,
  input  logic [8:0] int_line,
  input  logic       int_en,
  input  logic       int_ack,
  output logic [9:0] h_count,
  output logic [8:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       display_active,
  output logic       parity,
  output logic       line_start,
  output logic       frame_start,
  output logic       irq
);

  localparam logic [9:0] LP_H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_H_ACTIVE    = 10'(H_ACTIVE);
  localparam logic [9:0] LP_HS_START    = 10'(HS_START);
  localparam logic [9:0] LP_HS_END      = 10'(HS_START + HS_WIDTH);
  localparam logic [8:0] LP_V_LAST_PAL  = 9'(V_TOTAL_PAL - 1);
  localparam logic [8:0] LP_V_LAST_NTSC = 9'(V_TOTAL_NTSC - 1);
  localparam logic [8:0] LP_VA_PAL      = 9'(V_ACTIVE_PAL);
  localparam logic [8:0] LP_VA_NTSC     = 9'(V_ACTIVE_NTSC);
  localparam logic [8:0] LP_VS_OFFSET   = 9'(VS_OFFSET);
  localparam logic [8:0] LP_VS_WIDTH    = 9'(VS_WIDTH);

  // Parameter sanity: sync windows must fit inside their totals.
  if (HS_START + HS_WIDTH > H_TOTAL) begin : g_bad_hsync
    $error("mcd212_video_timing: hsync window exceeds H_TOTAL");
  end
  if (V_ACTIVE_PAL + VS_OFFSET + VS_WIDTH > V_TOTAL_PAL) begin : g_bad_vsync_pal
    $error("mcd212_video_timing: PAL vsync window exceeds V_TOTAL_PAL");
  end
  if (V_ACTIVE_NTSC + VS_OFFSET + VS_WIDTH > V_TOTAL_NTSC) begin : g_bad_vsync_ntsc
    $error("mcd212_video_timing: NTSC vsync window exceeds V_TOTAL_NTSC");
  end

  logic [9:0] r_h_count;
  logic [8:0] r_v_count;
  logic       r_parity;
  logic       r_mode_pal;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_hblank;
  logic       r_vblank;
  logic       r_line_start;
  logic       r_frame_start;
  logic       r_irq;

  logic [8:0] w_v_last;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_next;
  logic [8:0] w_v_next;
  logic       w_mode_next;
  logic [8:0] w_v_active;
  logic [8:0] w_vs_start;
  logic [8:0] w_vs_end;
  logic       w_irq_set;

  // The field length in force is the one latched at the last field wrap.
  assign w_v_last    = r_mode_pal ? LP_V_LAST_PAL : LP_V_LAST_NTSC;
  assign w_h_wrap    = (r_h_count == LP_H_LAST);
  assign w_v_wrap    = w_h_wrap && (r_v_count == w_v_last);
  assign w_h_next    = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
  assign w_v_next    = w_v_wrap ? 9'd0 : (w_h_wrap ? r_v_count + 9'd1 : r_v_count);
  assign w_mode_next = w_v_wrap ? pal : r_mode_pal;

  // Vertical decode uses the mode that will be in force alongside w_v_next.
  assign w_v_active  = w_mode_next ? LP_VA_PAL : LP_VA_NTSC;
  assign w_vs_start  = w_v_active + LP_VS_OFFSET;
  assign w_vs_end    = w_vs_start + LP_VS_WIDTH;

  // w_v_next never reaches v_total, so an out-of-range int_line cannot match.
  assign w_irq_set   = pixel_ce && w_h_wrap && int_en && (w_v_next == int_line);

  // Position counters, field parity and the per-field standard latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_count  <= 10'd0;
      r_v_count  <= 9'd0;
      r_parity   <= 1'b0;
      r_mode_pal <= 1'b1;
    end else if (pixel_ce) begin
      r_h_count  <= w_h_next;
      r_v_count  <= w_v_next;
      r_mode_pal <= w_mode_next;
      if (w_v_wrap) begin
        r_parity <= ~r_parity;
      end
    end
  end

  // Registered sync/blank decodes taken from the next-state counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_hblank <= 1'b0;
      r_vblank <= 1'b0;
    end else if (pixel_ce) begin
      r_hblank <= (w_h_next >= LP_H_ACTIVE);
      r_hsync  <= (w_h_next >= LP_HS_START) && (w_h_next < LP_HS_END);
      r_vblank <= (w_v_next >= w_v_active);
      r_vsync  <= (w_v_next >= w_vs_start) && (w_v_next < w_vs_end);
    end
  end

  // Single-clock line/frame strobes; they drop on any clock without pixel_ce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= pixel_ce && w_h_wrap;
      r_frame_start <= pixel_ce && w_v_wrap;
    end
  end

  // Sticky line interrupt; a set in the same clock as an ack takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (int_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign h_count        = r_h_count;
  assign v_count        = r_v_count;
  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign hblank         = r_hblank;
  assign vblank         = r_vblank;
  assign display_active = ~r_vblank;
  assign parity         = r_parity;
  assign line_start     = r_line_start;
  assign frame_start    = r_frame_start;
  assign irq            = r_irq;

endmodule

// File: tb/tb_mcd212_video_timing.sv
// Bench for mcd212_video_timing. A default-parameter instance (dut_d) covers
// the real horizontal timing; a short-line instance (dut_s, 40 clks/line,
// default vertical timing) makes whole PAL/NTSC fields affordable.
module tb_mcd212_video_timing;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_ce = 1'b0;
  logic       pal = 1'b1;
  logic [8:0] int_line = 9'd0;
  logic       int_en = 1'b0;
  logic       int_ack = 1'b0;

  logic [9:0] d_h;
  logic [8:0] d_v;
  logic d_hsync, d_vsync, d_hblank, d_vblank, d_da, d_par, d_ls, d_fs, d_irq;
  logic [9:0] s_h;
  logic [8:0] s_v;
  logic s_hsync, s_vsync, s_hblank, s_vblank, s_da, s_par, s_ls, s_fs, s_irq;

  int errors = 0;
  int checks = 0;
  int n = 0;

  // reference model for dut_s
  logic [9:0] m_h;
  logic [8:0] m_v;
  logic m_par, m_mode, m_ls, m_fs, m_irq;
  int s_bad = 0;
  int s_first_n = -1;
  logic [27:0] s_first_act, s_first_exp;

  always #5 clk = ~clk;

  mcd212_video_timing dut_d (
    .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .pal(pal),
    .int_line(int_line), .int_en(int_en), .int_ack(int_ack),
    .h_count(d_h), .v_count(d_v), .hsync(d_hsync), .vsync(d_vsync),
    .hblank(d_hblank), .vblank(d_vblank), .display_active(d_da),
    .parity(d_par), .line_start(d_ls), .frame_start(d_fs), .irq(d_irq)
  );

  mcd212_video_timing #(
    .H_TOTAL(40), .H_ACTIVE(32), .HS_START(34), .HS_WIDTH(4)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .pal(pal),
    .int_line(int_line), .int_en(int_en), .int_ack(int_ack),
    .h_count(s_h), .v_count(s_v), .hsync(s_hsync), .vsync(s_vsync),
    .hblank(s_hblank), .vblank(s_vblank), .display_active(s_da),
    .parity(s_par), .line_start(s_ls), .frame_start(s_fs), .irq(s_irq)
  );

  function automatic logic [27:0] act_s();
    return {s_h, s_v, s_hsync, s_vsync, s_hblank, s_vblank, s_da, s_par, s_ls, s_fs, s_irq};
  endfunction

  function automatic logic [27:0] exp_s();
    logic [8:0] va;
    logic hb, hs, vb, vs;
    va = m_mode ? 9'd280 : 9'd240;
    hb = (m_h >= 10'd32);
    hs = (m_h >= 10'd34) && (m_h < 10'd38);
    vb = (m_v >= va);
    vs = (m_v >= va + 9'd4) && (m_v < va + 9'd7);
    return {m_h, m_v, hs, vs, hb, vb, ~vb, m_par, m_ls, m_fs, m_irq};
  endfunction

  task automatic model_reset();
    m_h = 10'd0; m_v = 9'd0; m_par = 1'b0; m_mode = 1'b1;
    m_ls = 1'b0; m_fs = 1'b0; m_irq = 1'b0;
  endtask

  // advance the model with the current inputs, then let the DUTs take the edge
  task automatic clk_tick();
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (pixel_ce) begin
      if (m_h == 10'd39) begin
        m_h = 10'd0;
        m_ls = 1'b1;
        if (m_v == (m_mode ? 9'd311 : 9'd261)) begin
          m_v = 9'd0; m_par = ~m_par; m_mode = pal; m_fs = 1'b1;
        end else begin
          m_v = m_v + 9'd1;
        end
      end else begin
        m_h = m_h + 10'd1;
      end
    end
    if (m_ls && int_en && (m_v == int_line)) m_irq = 1'b1;
    else if (int_ack) m_irq = 1'b0;
    @(posedge clk);
    #1;
    n++;
    if (act_s() !== exp_s()) begin
      s_bad++;
      if (s_first_n < 0) begin
        s_first_n = n; s_first_act = act_s(); s_first_exp = exp_s();
      end
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) clk_tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pixel_ce = 1'b0; pal = 1'b1;
    int_en = 1'b0; int_ack = 1'b0; int_line = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    s_bad = 0; s_first_n = -1; n = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pixel_ce = 1'b1; pal = 1'b1;
    int_en = 1'b1; int_line = 9'd0; int_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (d_h !== 10'd0) begin errors++; $display("FAIL reset_h_count: got %0d expected 0", d_h); end
    checks++; if (d_v !== 9'd0) begin errors++; $display("FAIL reset_v_count: got %0d expected 0", d_v); end
    checks++; if ({d_hsync, d_vsync, d_hblank, d_vblank} !== 4'b0000) begin errors++;
      $display("FAIL reset_sync_blank: got %b expected 0000", {d_hsync, d_vsync, d_hblank, d_vblank}); end
    checks++; if (d_da !== 1'b1) begin errors++; $display("FAIL reset_display_active: got %b expected 1", d_da); end
    checks++; if (d_par !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b expected 0", d_par); end
    checks++; if ({d_ls, d_fs} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {d_ls, d_fs}); end
    checks++; if (d_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", d_irq); end
    checks++; if (act_s() !== exp_s()) begin errors++; $display("FAIL reset_short_instance: got %h expected %h", act_s(), exp_s()); end
  endtask

  task automatic test_horizontal();
    int d_bad;
    int eh, ev;
    d_bad = 0;
    do_reset();
    pixel_ce = 1'b1;
    for (int i = 1; i <= 946; i++) begin
      clk_tick();
      eh = i % 944;
      ev = i / 944;
      if (d_h !== 10'(eh) || d_v !== 9'(ev) || d_hblank !== (eh >= 768) ||
          d_hsync !== (eh >= 800 && eh < 870) || d_ls !== (eh == 0) ||
          d_fs !== 1'b0 || d_vblank !== 1'b0 || d_da !== 1'b1) d_bad++;
      if (i == 767) begin checks++; if (d_hblank !== 1'b0) begin errors++; $display("FAIL hblank_at_767: got %b expected 0", d_hblank); end end
      if (i == 768) begin checks++; if (d_hblank !== 1'b1) begin errors++; $display("FAIL hblank_at_768: got %b expected 1", d_hblank); end end
      if (i == 799) begin checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL hsync_at_799: got %b expected 0", d_hsync); end end
      if (i == 800) begin checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL hsync_at_800: got %b expected 1", d_hsync); end end
      if (i == 869) begin checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL hsync_at_869: got %b expected 1", d_hsync); end end
      if (i == 870) begin checks++; if (d_hsync !== 1'b0) begin errors++; $display("FAIL hsync_at_870: got %b expected 0", d_hsync); end end
      if (i == 944) begin checks++;
        if ({d_ls, d_hblank, d_hsync, d_h, d_v} !== {1'b1, 1'b0, 1'b0, 10'd0, 9'd1}) begin errors++;
          $display("FAIL line_wrap: got ls=%b hb=%b hs=%b h=%0d v=%0d expected ls=1 hb=0 hs=0 h=0 v=1",
                   d_ls, d_hblank, d_hsync, d_h, d_v); end
      end
    end
    checks++; if (d_bad !== 0) begin errors++; $display("FAIL horiz_sweep: got %0d bad clks expected 0", d_bad); end
    checks++; if (s_bad !== 0) begin errors++;
      $display("FAIL horiz_short_model: got %0d bad clks expected 0 (first n=%0d act=%h exp=%h)", s_bad, s_first_n, s_first_act, s_first_exp); end
  endtask

  task automatic test_pal_field();
    int ls_cnt, fs_first, vb_first, vs_first, vs_last, d_ls_first, d_ls_cnt;
    logic par_before, par_after, da_before, da_at, vb_wrap;
    ls_cnt = 0; fs_first = -1; vb_first = -1; vs_first = -1; vs_last = -1;
    d_ls_first = -1; d_ls_cnt = 0;
    par_before = 1'bx; par_after = 1'bx; da_before = 1'bx; da_at = 1'bx; vb_wrap = 1'bx;
    do_reset();
    pixel_ce = 1'b1;
    for (int i = 1; i <= 12520; i++) begin
      clk_tick();
      if (s_ls === 1'b1) ls_cnt++;
      if (s_fs === 1'b1 && fs_first < 0) fs_first = i;
      if (s_vblank === 1'b1 && vb_first < 0) vb_first = i;
      if (s_vsync === 1'b1 && vs_first < 0) vs_first = i;
      if (s_vsync === 1'b1) vs_last = i;
      if (d_ls === 1'b1) begin d_ls_cnt++; if (d_ls_first < 0) d_ls_first = i; end
      if (i == 11199) da_before = s_da;
      if (i == 11200) da_at = s_da;
      if (i == 12479) par_before = s_par;
      if (i == 12480) begin par_after = s_par; vb_wrap = s_vblank; end
    end
    checks++; if (ls_cnt !== 313) begin errors++; $display("FAIL pal_line_count: got %0d expected 313", ls_cnt); end
    checks++; if (fs_first !== 12480) begin errors++; $display("FAIL pal_frame_period: got %0d expected 12480", fs_first); end
    checks++; if (vb_first !== 11200) begin errors++; $display("FAIL pal_vblank_start: got %0d expected 11200", vb_first); end
    checks++; if ({da_before, da_at} !== 2'b10) begin errors++; $display("FAIL pal_da_edge: got %b expected 10", {da_before, da_at}); end
    checks++; if (vs_first !== 11360) begin errors++; $display("FAIL pal_vsync_start: got %0d expected 11360", vs_first); end
    checks++; if (vs_last !== 11479) begin errors++; $display("FAIL pal_vsync_end: got %0d expected 11479", vs_last); end
    checks++; if ({par_before, par_after} !== 2'b01) begin errors++; $display("FAIL pal_parity_toggle: got %b expected 01", {par_before, par_after}); end
    checks++; if (vb_wrap !== 1'b0) begin errors++; $display("FAIL pal_vblank_wrap: got %b expected 0", vb_wrap); end
    checks++; if (d_ls_first !== 944) begin errors++; $display("FAIL full_line_period: got %0d expected 944", d_ls_first); end
    checks++; if (d_ls_cnt !== 13) begin errors++; $display("FAIL full_line_count: got %0d expected 13", d_ls_cnt); end
    checks++; if (s_bad !== 0) begin errors++;
      $display("FAIL pal_model: got %0d bad clks expected 0 (first n=%0d act=%h exp=%h)", s_bad, s_first_n, s_first_act, s_first_exp); end
  endtask

  task automatic test_mode_switch();
    int fs1, fs2, vb2, vs2, irq_cnt;
    logic [8:0] v_last_pal, v_last_ntsc;
    logic par1, par2;
    fs1 = -1; fs2 = -1; vb2 = -1; vs2 = -1; irq_cnt = 0;
    v_last_pal = 9'h1ff; v_last_ntsc = 9'h1ff; par1 = 1'bx; par2 = 1'bx;
    do_reset();
    pixel_ce = 1'b1;
    for (int i = 1; i <= 23000; i++) begin
      clk_tick();
      if (s_fs === 1'b1) begin if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i; end
      if (i > 12480 && s_vblank === 1'b1 && vb2 < 0) vb2 = i;
      if (i > 12480 && s_vsync === 1'b1 && vs2 < 0) vs2 = i;
      if (s_irq === 1'b1) irq_cnt++;
      if (i == 12479) v_last_pal = s_v;
      if (i == 22959) v_last_ntsc = s_v;
      if (i == 12480) par1 = s_par;
      if (i == 22960) par2 = s_par;
      if (i == 4000) pal = 1'b0;
      if (i == 12480) begin int_en = 1'b1; int_line = 9'd300; end
    end
    checks++; if (fs1 !== 12480) begin errors++; $display("FAIL switch_first_field: got %0d expected 12480", fs1); end
    checks++; if (v_last_pal !== 9'd311) begin errors++; $display("FAIL switch_last_pal_line: got %0d expected 311", v_last_pal); end
    checks++; if (fs2 !== 22960) begin errors++; $display("FAIL switch_ntsc_field: got %0d expected 22960", fs2); end
    checks++; if (v_last_ntsc !== 9'd261) begin errors++; $display("FAIL switch_last_ntsc_line: got %0d expected 261", v_last_ntsc); end
    checks++; if (vb2 !== 22080) begin errors++; $display("FAIL ntsc_vblank_start: got %0d expected 22080", vb2); end
    checks++; if (vs2 !== 22240) begin errors++; $display("FAIL ntsc_vsync_start: got %0d expected 22240", vs2); end
    checks++; if ({par1, par2} !== 2'b10) begin errors++; $display("FAIL switch_parity: got %b expected 10", {par1, par2}); end
    checks++; if (irq_cnt !== 0) begin errors++; $display("FAIL ntsc_line300_irq: got %0d irq clks expected 0", irq_cnt); end
    checks++; if (s_bad !== 0) begin errors++;
      $display("FAIL switch_model: got %0d bad clks expected 0 (first n=%0d act=%h exp=%h)", s_bad, s_first_n, s_first_act, s_first_exp); end
  endtask

  task automatic test_line_irq();
    do_reset();
    pixel_ce = 1'b1; int_en = 1'b1; int_line = 9'd100;
    run_to(3999);
    checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_before_line: got %b expected 0", s_irq); end
    clk_tick();
    checks++; if ({s_irq, s_ls, s_v} !== {1'b1, 1'b1, 9'd100}) begin errors++;
      $display("FAIL irq_rise: got irq=%b ls=%b v=%0d expected irq=1 ls=1 v=100", s_irq, s_ls, s_v); end
    run_to(4005);
    checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", s_irq); end
    int_ack = 1'b1; clk_tick(); int_ack = 1'b0;
    checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_ack_clear: got %b expected 0", s_irq); end
    int_line = 9'd101;
    run_to(4039);
    int_ack = 1'b1; clk_tick(); int_ack = 1'b0;
    checks++; if ({s_irq, s_ls} !== 2'b11) begin errors++; $display("FAIL irq_set_beats_ack: got irq,ls=%b expected 11", {s_irq, s_ls}); end
    int_ack = 1'b1; clk_tick(); int_ack = 1'b0;
    int_line = 9'd102;
    checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_ack_clear2: got %b expected 0", s_irq); end
    run_to(4080);
    checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_line102: got %b expected 1", s_irq); end
    int_en = 1'b0;
    run_to(4100);
    checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_en_low_keeps: got %b expected 1", s_irq); end
    int_ack = 1'b1; clk_tick(); int_ack = 1'b0;
    int_line = 9'd103;
    run_to(4125);
    checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_en_low_blocks: got %b expected 0", s_irq); end
    checks++; if (s_bad !== 0) begin errors++;
      $display("FAIL irq_model: got %0d bad clks expected 0 (first n=%0d act=%h exp=%h)", s_bad, s_first_n, s_first_act, s_first_exp); end
  endtask

  task automatic test_ce_and_reset();
    int ls_cnt, ls_first, wide;
    logic prev_ls;
    ls_cnt = 0; ls_first = -1; wide = 0; prev_ls = 1'b0;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      pixel_ce = ((k % 3) == 0);
      clk_tick();
      if (s_ls === 1'b1) begin ls_cnt++; if (ls_first < 0) ls_first = k; end
      if (s_ls === 1'b1 && prev_ls === 1'b1) wide++;
      prev_ls = s_ls;
    end
    pixel_ce = 1'b0;
    checks++; if (ls_cnt !== 2) begin errors++; $display("FAIL ce_line_count: got %0d expected 2", ls_cnt); end
    checks++; if (ls_first !== 117) begin errors++; $display("FAIL ce_line_first: got %0d expected 117", ls_first); end
    checks++; if (wide !== 0) begin errors++; $display("FAIL ce_strobe_width: got %0d wide strobes expected 0", wide); end
    checks++; if ({s_h, s_v} !== {10'd20, 9'd2}) begin errors++; $display("FAIL ce_position: got h=%0d v=%0d expected h=20 v=2", s_h, s_v); end
    checks++; if (s_bad !== 0) begin errors++;
      $display("FAIL ce_model: got %0d bad clks expected 0 (first n=%0d act=%h exp=%h)", s_bad, s_first_n, s_first_act, s_first_exp); end
    pixel_ce = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (act_s() !== {10'd0, 9'd0, 9'b000010000}) begin errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", act_s(), {10'd0, 9'd0, 9'b000010000}); end
    checks++; if ({d_h, d_v, d_da, d_ls, d_irq} !== {10'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin errors++;
      $display("FAIL async_reset_full: got h=%0d v=%0d da=%b ls=%b irq=%b expected 0 0 1 0 0", d_h, d_v, d_da, d_ls, d_irq); end
    @(posedge clk);
    #1;
    model_reset();
    s_bad = 0; s_first_n = -1;
    reset_n = 1'b1;
    clk_tick();
    checks++; if ({s_h, s_v, s_ls} !== {10'd1, 9'd0, 1'b0}) begin errors++;
      $display("FAIL restart_after_reset: got h=%0d v=%0d ls=%b expected h=1 v=0 ls=0", s_h, s_v, s_ls); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_pal_field();
    test_mode_switch();
    test_line_irq();
    test_ce_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
